// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding control for the 5-stage core: forward selects, load-use stall, branch flush, memory freeze.
// All controls are combinational, valid the same cycle; mem_busy holds every stage, including this block's shadow copy.
module hazard_forward_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_branch_taken,
   input  logic              mem_busy,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              pc_we,
   output logic              id_ex_bubble,
   output logic              if_id_flush,
   output logic              pipe_freeze,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LU_STALL = 2'b01,
      ST_FLUSH    = 2'b10,
      ST_FREEZE   = 2'b11
   } state_e;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } prod_t;

   prod_t             ex_prod, mem_prod, wb_prod;
   logic [REG_AW-1:0] ex_rs1, ex_rs2;
   logic              ex_uses_rs1, ex_uses_rs2;

   state_e state_q, next_state;
   logic   lu_hazard;

   function automatic logic prod_match(input prod_t p, input logic [REG_AW-1:0] rs, input logic uses);
      return p.valid && p.regwrite && (p.rd != '0) && (p.rd == rs) && uses;
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic uses);
      logic [1:0] sel;
      sel = 2'b00;
      if (prod_match(mem_prod, rs, uses))
         sel = 2'b10;
      else if (prod_match(wb_prod, rs, uses))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      forward_a = fwd_sel(ex_rs1, ex_uses_rs1);
      forward_b = fwd_sel(ex_rs2, ex_uses_rs2);
   end

   // A load in EX cannot supply its data until WB, so the dependent ID instruction must wait one cycle.
   always_comb begin
      lu_hazard = ex_prod.valid && ex_prod.memread && (ex_prod.rd != '0) && id_valid &&
                  ((id_uses_rs1 && (id_rs1 == ex_prod.rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_prod.rd)));
   end

   // Decision for this cycle; the branch stays in EX during a freeze, so it is re-evaluated afterwards.
   always_comb begin
      next_state = ST_RUN;
      if (rst)
         next_state = ST_RUN;
      else if (mem_busy)
         next_state = ST_FREEZE;
      else if (ex_branch_taken)
         next_state = ST_FLUSH;
      else if (lu_hazard)
         next_state = ST_LU_STALL;
   end

   always_comb begin
      pc_we        = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      pipe_freeze  = 1'b0;
      unique case (next_state)
         ST_FREEZE: begin
            pc_we       = 1'b0;
            pipe_freeze = 1'b1;
         end
         ST_FLUSH: begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
         end
         ST_LU_STALL: begin
            pc_we        = 1'b0;
            id_ex_bubble = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_RUN;
      else
         state_q <= next_state;
   end

   assign state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (!pc_we && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_prod     <= '0;
         mem_prod    <= '0;
         wb_prod     <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_uses_rs1 <= 1'b0;
         ex_uses_rs2 <= 1'b0;
      end else if (!pipe_freeze) begin
         wb_prod  <= mem_prod;
         mem_prod <= ex_prod;
         if (id_ex_bubble) begin
            ex_prod.valid <= 1'b0;
         end else begin
            ex_prod     <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_uses_rs1 <= id_uses_rs1;
            ex_uses_rs2 <= id_uses_rs2;
         end
      end
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios then random traffic,
// every output compared each cycle against a stage-level model of the pipeline.
module tb_hazard_forward_ctrl;
   localparam int AW   = 5;
   localparam int CW   = 5;
   localparam int CMAX = (1 << CW) - 1;
   localparam int D_RUN = 0, D_LU = 1, D_FLUSH = 2, D_FREEZE = 3;

   typedef struct {
      bit valid;
      int rd, rs1, rs2;
      bit u1, u2, rw, mr;
   } instr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
   logic [AW-1:0] id_rs1, id_rs2, id_rd;
   logic          ex_branch_taken, mem_busy;
   logic [1:0]    forward_a, forward_b, state;
   logic          pc_we, id_ex_bubble, if_id_flush, pipe_freeze;
   logic [CW-1:0] stall_cnt;

   hazard_forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .forward_a(forward_a), .forward_b(forward_b), .pc_we(pc_we),
      .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
      .pipe_freeze(pipe_freeze), .state(state), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int     n_vec = 0;
   int     n_err = 0;
   instr_t m_ex, m_mem, m_wb, cur;
   bit     cur_br, cur_busy;
   int     m_state, m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic instr_t nop();
      instr_t t;
      t.valid = 0; t.rd = 0; t.rs1 = 0; t.rs2 = 0;
      t.u1 = 0; t.u2 = 0; t.rw = 0; t.mr = 0;
      return t;
   endfunction

   function automatic instr_t alu(input int rd, input int rs1, input int rs2);
      instr_t t;
      t = nop();
      t.valid = 1; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
      t.u1 = 1; t.u2 = 1; t.rw = 1;
      return t;
   endfunction

   function automatic instr_t lw(input int rd, input int rs1);
      instr_t t;
      t = nop();
      t.valid = 1; t.rd = rd; t.rs1 = rs1;
      t.u1 = 1; t.rw = 1; t.mr = 1;
      return t;
   endfunction

   function automatic bit writes(input instr_t p, input int r);
      return p.valid && p.rw && p.rd != 0 && p.rd == r;
   endfunction

   function automatic int fwd(input int rs, input bit used);
      if (used && writes(m_mem, rs)) return 2;
      if (used && writes(m_wb, rs)) return 1;
      return 0;
   endfunction

   function automatic int decide();
      bit lu;
      lu = m_ex.valid && m_ex.mr && m_ex.rd != 0 && cur.valid &&
           ((cur.u1 && cur.rs1 == m_ex.rd) || (cur.u2 && cur.rs2 == m_ex.rd));
      if (cur_busy) return D_FREEZE;
      if (cur_br)   return D_FLUSH;
      if (lu)       return D_LU;
      return D_RUN;
   endfunction

   task automatic model_reset();
      m_ex = nop(); m_mem = nop(); m_wb = nop();
      m_state = D_RUN; m_cnt = 0;
   endtask

   task automatic apply(input instr_t i, input bit br = 0, input bit busy = 0);
      int d;
      cur = i; cur_br = br; cur_busy = busy;
      id_valid = i.valid; id_rd = i.rd[AW-1:0];
      id_rs1 = i.rs1[AW-1:0]; id_rs2 = i.rs2[AW-1:0];
      id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
      id_regwrite = i.rw; id_memread = i.mr;
      ex_branch_taken = br; mem_busy = busy;
      #1;
      d = decide();
      chk("forward_a", forward_a, fwd(m_ex.rs1, m_ex.u1));
      chk("forward_b", forward_b, fwd(m_ex.rs2, m_ex.u2));
      chk("pc_we", pc_we, (d == D_RUN || d == D_FLUSH));
      chk("id_ex_bubble", id_ex_bubble, (d == D_LU || d == D_FLUSH));
      chk("if_id_flush", if_id_flush, (d == D_FLUSH));
      chk("pipe_freeze", pipe_freeze, (d == D_FREEZE));
      chk("state", state, m_state);
      chk("stall_cnt", stall_cnt, m_cnt);
   endtask

   task automatic tick();
      int d;
      d = decide();
      if (d != D_FREEZE) begin
         m_wb  = m_mem;
         m_mem = m_ex;
         if (d == D_LU || d == D_FLUSH) m_ex.valid = 0;
         else m_ex = cur;
      end
      m_state = d;
      if (!(d == D_RUN || d == D_FLUSH) && m_cnt < CMAX) m_cnt++;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse placed mid-cycle, away from either clock edge.
   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_pc_we", pc_we, 1);
      chk("rst_bubble", id_ex_bubble, 0);
      chk("rst_flush", if_id_flush, 0);
      chk("rst_freeze", pipe_freeze, 0);
      chk("rst_fwd_a", forward_a, 0);
      chk("rst_fwd_b", forward_b, 0);
      chk("rst_state", state, 0);
      chk("rst_cnt", stall_cnt, 0);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      apply(nop());
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();

      // Back-to-back, one-gap and two-gap ALU dependencies.
      apply(alu(5, 1, 2)); tick();
      apply(alu(6, 5, 1)); tick();
      apply(nop()); chk("b2b_fwd_a", forward_a, 2); tick();
      apply(alu(5, 1, 2)); tick();
      apply(nop()); tick();
      apply(alu(6, 5, 1)); tick();
      apply(nop()); chk("gap1_fwd_a", forward_a, 1); tick();
      apply(alu(5, 1, 2)); tick();
      apply(nop()); tick();
      apply(nop()); tick();
      apply(alu(6, 5, 1)); tick();
      apply(nop()); chk("gap2_fwd_a", forward_a, 0); tick();

      // MEM beats WB when both write the same register.
      apply(alu(7, 1, 2)); tick();
      apply(alu(7, 3, 4)); tick();
      apply(alu(10, 1, 7)); tick();
      apply(nop()); chk("prio_fwd_b", forward_b, 2); tick();

      // Load-use: one stall cycle, then the consumer takes the load data from WB.
      pulse_reset();
      apply(lw(8, 1)); tick();
      apply(alu(9, 8, 2));
      chk("lu_pc_we", pc_we, 0); chk("lu_bubble", id_ex_bubble, 1);
      tick();
      apply(alu(9, 8, 2));
      chk("lu_state", state, 1); chk("lu_cnt", stall_cnt, 1); chk("lu_clear", pc_we, 1);
      tick();
      apply(nop()); chk("lu_fwd_a", forward_a, 1); tick();

      // A taken branch overrides a simultaneous load-use hazard.
      apply(lw(8, 1)); tick();
      apply(alu(9, 8, 2), 1'b1);
      chk("br_flush", if_id_flush, 1); chk("br_bubble", id_ex_bubble, 1); chk("br_pc_we", pc_we, 1);
      tick();

      // Three busy cycles hold a pending branch and the forward selects.
      pulse_reset();
      apply(alu(5, 1, 2)); tick();
      apply(alu(6, 5, 1)); tick();
      for (int c = 0; c < 3; c++) begin
         apply(alu(11, 3, 4), 1'b1, 1'b1);
         chk("frz_freeze", pipe_freeze, 1); chk("frz_flush", if_id_flush, 0);
         chk("frz_fwd_a", forward_a, 2);
         tick();
      end
      apply(alu(11, 3, 4), 1'b1, 1'b0);
      chk("frz_end_flush", if_id_flush, 1); chk("frz_cnt", stall_cnt, 3);
      tick();

      // x0 never forwards and never stalls.
      apply(alu(0, 1, 2)); tick();
      apply(alu(6, 0, 0)); tick();
      apply(nop()); chk("x0_fwd_a", forward_a, 0); chk("x0_fwd_b", forward_b, 0); tick();
      apply(lw(0, 1)); tick();
      apply(alu(6, 0, 0)); chk("x0_no_stall", pc_we, 1); tick();

      // Reset during a load-use stall.
      apply(lw(8, 1)); tick();
      apply(alu(9, 8, 2)); chk("pre_rst_stall", pc_we, 0);
      pulse_reset();
      tick();

      // Random traffic over a small register set to provoke hazards.
      for (int k = 0; k < 3000; k++) begin
         instr_t r;
         r.valid = ($urandom_range(0, 7) != 0);
         r.rd  = $urandom_range(0, 7);
         r.rs1 = $urandom_range(0, 7);
         r.rs2 = $urandom_range(0, 7);
         r.u1  = $urandom_range(0, 1);
         r.u2  = $urandom_range(0, 1);
         r.rw  = $urandom_range(0, 1);
         r.mr  = ($urandom_range(0, 2) == 0);
         apply(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
         if (k % 700 == 350) pulse_reset();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
